// File: rtl/hpdcache_cfg_pkg.sv
// Shared constants and types for the HPDcache runtime configuration controller.
package hpdcache_cfg_pkg;

  localparam logic [1:0] RegCtrl    = 2'd0;
  localparam logic [1:0] RegWayEn   = 2'd1;
  localparam logic [1:0] RegWbufThr = 2'd2;
  localparam logic [1:0] RegStatus  = 2'd3;

  localparam int unsigned CtrlResetTimecntBit = 0;
  localparam int unsigned CtrlSeqWawBit       = 1;

  localparam int unsigned StatusCntLsb  = 0;
  localparam int unsigned StatusWaysLsb = 8;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StResp
  } cfg_state_e;

endpackage

// File: rtl/hpdcache_cfg_drain_ctrl.sv
// Drain wait timer: counts cycles spent waiting for the cache to go idle and
// arbitrates idle against timeout (idle wins when both land in the same cycle).
module hpdcache_cfg_drain_ctrl #(
  parameter int unsigned DRAIN_TIMEOUT = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic active_i,
  input  logic cache_idle_i,
  output logic done_o,
  output logic timeout_o
);

  localparam int unsigned TimerW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(DRAIN_TIMEOUT - 1);

  logic [TimerW-1:0] timer_q, timer_d;

  // Timer value k-1 in the k-th drain cycle, so the timeout fires on the
  // DRAIN_TIMEOUT-th cycle of waiting.
  always_comb begin
    done_o    = active_i & cache_idle_i;
    timeout_o = active_i & ~cache_idle_i & (timer_q == TimerLast);
    timer_d   = timer_q;
    if (start_i) begin
      timer_d = '0;
    end else if (active_i && !done_o && !timeout_o) begin
      timer_d = timer_q + TimerW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/hpdcache_cfg_ctrl.sv
// Software-writable HPDcache configuration registers; way-enable changes are
// applied only once the cache has drained to idle.
module hpdcache_cfg_ctrl
  import hpdcache_cfg_pkg::*;
#(
  parameter int unsigned WAYS               = 4,
  parameter int unsigned WBUF_TIMECNT_WIDTH = 4,
  parameter int unsigned DRAIN_TIMEOUT      = 256,
  parameter int unsigned WBUF_THRESHOLD_RST = 2 ** WBUF_TIMECNT_WIDTH - 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          cfg_req_valid_i,
  output logic                          cfg_req_ready_o,
  input  logic                          cfg_req_we_i,
  input  logic [1:0]                    cfg_req_addr_i,
  input  logic [31:0]                   cfg_req_wdata_i,
  output logic                          cfg_rsp_valid_o,
  output logic [31:0]                   cfg_rsp_rdata_o,
  output logic                          cfg_rsp_error_o,
  input  logic                          cache_idle_i,
  output logic                          drain_req_o,
  output logic [WAYS-1:0]               cfg_way_en_o,
  output logic [WBUF_TIMECNT_WIDTH-1:0] cfg_wbuf_threshold_o,
  output logic                          cfg_wbuf_reset_timecnt_on_write_o,
  output logic                          cfg_wbuf_sequential_waw_o
);

  cfg_state_e                    state_q, state_d;
  logic [WAYS-1:0]               way_en_q, way_en_d;
  logic [WAYS-1:0]               pending_q, pending_d;
  logic [WBUF_TIMECNT_WIDTH-1:0] thr_q, thr_d;
  logic                          rtw_q, rtw_d;
  logic                          waw_q, waw_d;
  logic [7:0]                    to_cnt_q, to_cnt_d;
  logic [31:0]                   rdata_q, rdata_d;
  logic                          err_q, err_d;
  logic [31:0]                   read_data;
  logic                          drain_start;
  logic                          drain_done;
  logic                          drain_timeout;
  logic                          unused_wdata;

  // Upper write-data bits are architecturally ignored.
  assign unused_wdata = ^cfg_req_wdata_i;

  hpdcache_cfg_drain_ctrl #(
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
  ) u_drain_ctrl (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (drain_start),
    .active_i    (state_q == StDrain),
    .cache_idle_i(cache_idle_i),
    .done_o      (drain_done),
    .timeout_o   (drain_timeout)
  );

  always_comb begin
    read_data = '0;
    unique case (cfg_req_addr_i)
      RegCtrl: begin
        read_data[CtrlResetTimecntBit] = rtw_q;
        read_data[CtrlSeqWawBit]       = waw_q;
      end
      RegWayEn:   read_data = 32'(way_en_q);
      RegWbufThr: read_data = 32'(thr_q);
      RegStatus: begin
        read_data[StatusCntLsb +: 8]  = to_cnt_q;
        read_data[StatusWaysLsb +: 8] = 8'(WAYS);
      end
      default: read_data = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    way_en_d    = way_en_q;
    pending_d   = pending_q;
    thr_d       = thr_q;
    rtw_d       = rtw_q;
    waw_d       = waw_q;
    to_cnt_d    = to_cnt_q;
    rdata_d     = '0;
    err_d       = 1'b0;
    drain_start = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_req_valid_i) begin
          state_d = StResp;
          if (!cfg_req_we_i) begin
            rdata_d = read_data;
          end else begin
            unique case (cfg_req_addr_i)
              RegCtrl: begin
                rtw_d = cfg_req_wdata_i[CtrlResetTimecntBit];
                waw_d = cfg_req_wdata_i[CtrlSeqWawBit];
              end
              RegWayEn: begin
                if (cfg_req_wdata_i[WAYS-1:0] == '0) begin
                  err_d = 1'b1;
                end else begin
                  pending_d   = cfg_req_wdata_i[WAYS-1:0];
                  drain_start = 1'b1;
                  state_d     = StDrain;
                end
              end
              RegWbufThr: thr_d = cfg_req_wdata_i[WBUF_TIMECNT_WIDTH-1:0];
              RegStatus:  err_d = 1'b1;
              default:    err_d = 1'b1;
            endcase
          end
        end
      end
      StDrain: begin
        if (drain_done) begin
          way_en_d = pending_q;
          state_d  = StResp;
        end else if (drain_timeout) begin
          err_d   = 1'b1;
          state_d = StResp;
          if (to_cnt_q != 8'hFF) begin
            to_cnt_d = to_cnt_q + 8'd1;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      way_en_q  <= '1;
      pending_q <= '0;
      thr_q     <= WBUF_TIMECNT_WIDTH'(WBUF_THRESHOLD_RST);
      rtw_q     <= 1'b0;
      waw_q     <= 1'b0;
      to_cnt_q  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      way_en_q  <= way_en_d;
      pending_q <= pending_d;
      thr_q     <= thr_d;
      rtw_q     <= rtw_d;
      waw_q     <= waw_d;
      to_cnt_q  <= to_cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign cfg_req_ready_o                   = (state_q == StIdle);
  assign cfg_rsp_valid_o                   = (state_q == StResp);
  assign drain_req_o                       = (state_q == StDrain);
  assign cfg_rsp_rdata_o                   = rdata_q;
  assign cfg_rsp_error_o                   = err_q;
  assign cfg_way_en_o                      = way_en_q;
  assign cfg_wbuf_threshold_o              = thr_q;
  assign cfg_wbuf_reset_timecnt_on_write_o = rtw_q;
  assign cfg_wbuf_sequential_waw_o         = waw_q;

endmodule

// File: tb/tb_hpdcache_cfg_ctrl.sv
// Directed self-checking bench for hpdcache_cfg_ctrl (WAYS=4, 4-bit threshold,
// DRAIN_TIMEOUT=16).
module tb_hpdcache_cfg_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        cache_idle;
  logic        drain_req;
  logic [3:0]  way_en;
  logic [3:0]  wbuf_thr;
  logic        wbuf_rtw;
  logic        wbuf_waw;

  int n_checks = 0;
  int n_fail   = 0;

  hpdcache_cfg_ctrl #(
    .WAYS              (4),
    .WBUF_TIMECNT_WIDTH(4),
    .DRAIN_TIMEOUT     (16)
  ) dut (
    .clk_i                            (clk),
    .rst_ni                           (rst_n),
    .cfg_req_valid_i                  (req_valid),
    .cfg_req_ready_o                  (req_ready),
    .cfg_req_we_i                     (req_we),
    .cfg_req_addr_i                   (req_addr),
    .cfg_req_wdata_i                  (req_wdata),
    .cfg_rsp_valid_o                  (rsp_valid),
    .cfg_rsp_rdata_o                  (rsp_rdata),
    .cfg_rsp_error_o                  (rsp_error),
    .cache_idle_i                     (cache_idle),
    .drain_req_o                      (drain_req),
    .cfg_way_en_o                     (way_en),
    .cfg_wbuf_threshold_o             (wbuf_thr),
    .cfg_wbuf_reset_timecnt_on_write_o(wbuf_rtw),
    .cfg_wbuf_sequential_waw_o        (wbuf_waw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single edge; returns 1 ns into the cycle after acceptance.
  task automatic req(input logic we, input logic [1:0] addr, input logic [31:0] wdata);
    if (!req_ready) check_eq("req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 2'd0;
    req_wdata = 32'd0;
  endtask

  task automatic read_check(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    req(1'b0, addr, 32'd0);
    check_eq(tag, rsp_rdata, exp);
    tick();
  endtask

  // Way-enable write with idle held low; cyc is the response cycle after acceptance.
  task automatic timeout_req(input logic [31:0] mask, output int cyc);
    cache_idle = 1'b0;
    req(1'b1, 2'd1, mask);
    cyc = 1;
    while (!rsp_valid && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int drain_hi;
    int ready_hi;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 2'd0;
    req_wdata  = 32'd0;
    cache_idle = 1'b0;
    repeat (3) tick();

    check_eq("rst_way_en", 32'(way_en), 32'hF);
    check_eq("rst_thr", 32'(wbuf_thr), 32'd15);
    check_eq("rst_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_drain_req", 32'(drain_req), 32'd0);
    check_eq("rst_policy", {30'd0, wbuf_waw, wbuf_rtw}, 32'd0);
    check_eq("rst_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // STATUS read: WAYS in [15:8], zero timeouts.
    req(1'b0, 2'd3, 32'd0);
    check_eq("status_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("status_rdata", rsp_rdata, 32'h0000_0400);
    check_eq("status_err", 32'(rsp_error), 32'd0);
    check_eq("resp_ready", 32'(req_ready), 32'd0);
    tick();
    check_eq("post_resp_valid", 32'(rsp_valid), 32'd0);
    check_eq("post_resp_ready", 32'(req_ready), 32'd1);

    // Threshold write keeps only the low 4 bits.
    req(1'b1, 2'd2, 32'hFFFF_FFF5);
    check_eq("thr_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("thr_err", 32'(rsp_error), 32'd0);
    check_eq("thr_wr_rdata", rsp_rdata, 32'd0);
    check_eq("thr_value", 32'(wbuf_thr), 32'd5);
    tick();
    read_check("thr_read", 2'd2, 32'd5);

    req(1'b1, 2'd0, 32'hFFFF_FFFE);
    check_eq("ctrl_policy", {30'd0, wbuf_waw, wbuf_rtw}, 32'd2);
    tick();
    read_check("ctrl_read", 2'd0, 32'd2);

    // Way-enable with idle arriving on the 6th drain cycle.
    cache_idle = 1'b0;
    req(1'b1, 2'd1, 32'h3);
    drain_hi = 0;
    ready_hi = 0;
    for (int k = 1; k <= 6; k++) begin
      if (drain_req) drain_hi++;
      if (req_ready) ready_hi++;
      if (k == 6) cache_idle = 1'b1;
      tick();
    end
    check_eq("drain_hi_cycles", 32'(drain_hi), 32'd6);
    check_eq("drain_ready_hi", 32'(ready_hi), 32'd0);
    check_eq("drain_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("drain_err", 32'(rsp_error), 32'd0);
    check_eq("drain_way_en", 32'(way_en), 32'h3);
    check_eq("drain_req_low", 32'(drain_req), 32'd0);
    cache_idle = 1'b0;
    tick();

    // Idle on the last allowed drain cycle wins over the timeout.
    req(1'b1, 2'd1, 32'h7);
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) cache_idle = 1'b1;
      tick();
    end
    check_eq("tie_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("tie_err", 32'(rsp_error), 32'd0);
    check_eq("tie_way_en", 32'(way_en), 32'h7);
    cache_idle = 1'b0;
    tick();

    // Same-mask write still drains.
    req(1'b1, 2'd1, 32'h3);
    check_eq("same_mask_drain", 32'(drain_req), 32'd1);
    cache_idle = 1'b1;
    tick();
    check_eq("same_mask_way_en", 32'(way_en), 32'h3);
    cache_idle = 1'b0;
    tick();

    // Timeout: error response 17 cycles after acceptance, mask unchanged.
    timeout_req(32'h1, cyc);
    check_eq("to_latency", 32'(cyc), 32'd17);
    check_eq("to_err", 32'(rsp_error), 32'd1);
    check_eq("to_way_en", 32'(way_en), 32'h3);
    tick();
    read_check("to_status1", 2'd3, 32'h0000_0401);

    for (int i = 0; i < 299; i++) begin
      timeout_req(32'h1, cyc);
      tick();
    end
    check_eq("to_last_latency", 32'(cyc), 32'd17);
    read_check("to_status_sat", 2'd3, 32'h0000_04FF);

    // Rejected writes: masked-zero way enable and STATUS.
    req(1'b1, 2'd1, 32'hF0);
    check_eq("zero_mask_err", 32'(rsp_error), 32'd1);
    check_eq("zero_mask_drain", 32'(drain_req), 32'd0);
    check_eq("zero_mask_way_en", 32'(way_en), 32'h3);
    tick();
    req(1'b1, 2'd3, 32'hFFFF_FFFF);
    check_eq("status_wr_err", 32'(rsp_error), 32'd1);
    tick();
    read_check("status_unchanged", 2'd3, 32'h0000_04FF);
    read_check("way_en_read", 2'd1, 32'h3);

    // Reset in the middle of a drain.
    req(1'b1, 2'd1, 32'h1);
    tick();
    tick();
    check_eq("mid_drain_req", 32'(drain_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_drain_req", 32'(drain_req), 32'd0);
    check_eq("rst_mid_way_en", 32'(way_en), 32'hF);
    check_eq("rst_mid_ready", 32'(req_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    cyc = 0;
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid) cyc++;
      tick();
    end
    check_eq("rst_mid_no_rsp", 32'(cyc), 32'd0);
    check_eq("rst_mid_way_en_hold", 32'(way_en), 32'hF);
    check_eq("rst_mid_thr", 32'(wbuf_thr), 32'd15);
    read_check("rst_mid_status", 2'd3, 32'h0000_0400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
